// File: rtl/watch_pkg.sv
// Shared constants for the watch front-end sequencer:
// display modes, sequencer states and the edit field count.
package watch_pkg;

  localparam logic [2:0] WATCH     = 3'd0;
  localparam logic [2:0] STOPWATCH = 3'd1;
  localparam logic [2:0] ALARM     = 3'd2;
  localparam logic [2:0] DAY       = 3'd3;

  localparam int FIELD_COUNT = 4;

  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    SET    = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop sync -> debounce -> one-cycle press pulse.
// Ports: clk, reset (sync, high), btn (raw), press (registered pulse).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          accepted;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      accepted <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != accepted) begin
        if (cnt == LAST) begin
          accepted <= sync2;
          cnt      <= '0;
          // Only the 0->1 acceptance is a press.
          press    <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/watch_mode_sequencer.sv
// Button front-end: debounced events drive browse/set/commit FSM.
// Ports: clk, reset, btn_* (raw) -> mode, setValue, upTime, nextd,
// field, commit, abort (all registered).
module watch_mode_sequencer
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SET_TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_next,
  output logic [2:0] mode,
  output logic       setValue,
  output logic       upTime,
  output logic       nextd,
  output logic [1:0] field,
  output logic       commit,
  output logic       abort
);

  localparam int TW = (SET_TIMEOUT > 2) ?
                      $clog2(SET_TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(SET_TIMEOUT - 1);

  logic p_mode, p_set, p_up, p_next;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .btn(btn_mode), .press(p_mode));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk(clk), .reset(reset), .btn(btn_set), .press(p_set));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .reset(reset), .btn(btn_up), .press(p_up));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .reset(reset), .btn(btn_next), .press(p_next));

  // Priority set > next > up > mode; losers are dropped.
  logic set_ev, next_ev, up_ev, mode_ev, any_ev;
  assign set_ev  = p_set;
  assign next_ev = p_next & ~p_set;
  assign up_ev   = p_up & ~p_set & ~p_next;
  assign mode_ev = p_mode & ~p_set & ~p_next & ~p_up;
  // Any press, even an ignored one, keeps the edit alive.
  assign any_ev  = p_set | p_next | p_up | p_mode;

  logic multi_field;
  assign multi_field = (mode == WATCH) || (mode == ALARM);

  state_t        state;
  logic [TW-1:0] idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BROWSE;
      idle     <= '0;
      mode     <= WATCH;
      setValue <= 1'b0;
      upTime   <= 1'b0;
      nextd    <= 1'b0;
      field    <= '0;
      commit   <= 1'b0;
      abort    <= 1'b0;
    end else begin
      upTime <= 1'b0;
      nextd  <= 1'b0;
      commit <= 1'b0;
      abort  <= 1'b0;
      unique case (state)
        BROWSE: begin
          if (set_ev && mode != STOPWATCH) begin
            state    <= SET;
            setValue <= 1'b1;
            field    <= '0;
            idle     <= '0;
          end else if (mode_ev) begin
            mode <= {1'b0, mode[1:0] + 2'd1};
          end
        end
        SET: begin
          if (set_ev) begin
            state  <= COMMIT;
            commit <= 1'b1;
          end else if (any_ev) begin
            idle <= '0;
            if (up_ev) upTime <= 1'b1;
            if (next_ev && multi_field) begin
              nextd <= 1'b1;
              field <= field + 2'd1;
            end
          end else if (idle == IDLE_LAST) begin
            abort    <= 1'b1;
            setValue <= 1'b0;
            field    <= '0;
            state    <= BROWSE;
          end else begin
            idle <= idle + 1'b1;
          end
        end
        COMMIT: begin
          state    <= BROWSE;
          setValue <= 1'b0;
          field    <= '0;
        end
        default: state <= BROWSE;
      endcase
    end
  end

endmodule

// File: doc/watch_mode_sequencer.md
# watch_mode_sequencer

Front-end controller that turns the four raw push-buttons into the clean control signals of the watch controller: `mode[2:0]`, `setValue`, and single-cycle `upTime`/`nextd` pulses. It debounces and edge-detects each button and runs the browse/set/commit state machine. Its set session aborts on a timeout. All outputs are registered and connect directly to the watch controller's mode and edit inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a level change (≥2).
- `SET_TIMEOUT`, default 1024: idle cycles in SET before abort (≥4).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_mode`  in  1  raw button: cycle display mode.
- `btn_set`  in  1  raw button: enter or commit set.
- `btn_up`  in  1  raw button: increment the edited field.
- `btn_next`  in  1  raw button: advance to the next field.
- `mode`  out  3  0=WATCH, 1=STOPWATCH, 2=ALARM, 3=DAY.
- `setValue`  out  1  high while editing.
- `upTime`  out  1  one-cycle increment pulse.
- `nextd`  out  1  one-cycle next-field pulse.
- `field`  out  2  index of the field being edited.
- `commit`  out  1  one-cycle pulse: edit accepted.
- `abort`  out  1  one-cycle pulse: edit discarded by timeout.

## Operation
- **Per button synchronization:** 2-flop synchronizer, then a debouncer.
- **Debouncer:** the accepted level flips only after the synced input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any glitch clears the counter.
- **Press event:** one-cycle pulse on the accepted 0→1 transition. Holding a button produces exactly one event.
- **Event priority in the same cycle:** set > next > up > mode. Lower-priority events in that cycle are dropped.
- **State BROWSE:**
  - mode event: `mode` ← (`mode`+1) mod 4.
  - set event with `mode` ≠ STOPWATCH: go to SET, `setValue`=1, `field`=0, idle timer cleared.
  - set event in STOPWATCH: ignored.
  - up and next events: ignored.
- **State SET:**
  - up event: `upTime` pulse.
  - next event in WATCH or ALARM: `nextd` pulse, `field` ← (`field`+1) mod 4, so 3 wraps to 0.
  - next event in DAY: ignored; no pulse, `field` stays 0.
  - mode events: ignored; `mode` is frozen.
  - set event: go to COMMIT.
  - Idle timer counts cycles with no accepted event and clears on any event, including ignored ones. On reaching `SET_TIMEOUT`: `abort` pulse, go to BROWSE.
- **State COMMIT (1 cycle):** `commit`=1 and `setValue` still 1, then BROWSE with `setValue`=0 and `field`=0.
- **Reset:**
  - Outputs: `mode`=0, `setValue`=0, `upTime`=0, `nextd`=0, `field`=0, `commit`=0, `abort`=0.
  - Internals: state BROWSE, debouncers accepted=0, counters 0.
  - Reset during SET discards the edit; no `commit` and no `abort`.

## Timing
- Latency from a raw rising edge (held stable) to an output change: 2 (sync) + `DEBOUNCE_CYCLES` (debounce) + 1 (register) cycles.
- Pulse outputs are exactly one cycle wide.
- Back-to-back events from one button are separated by at least 2×`DEBOUNCE_CYCLES` cycles.
- `setValue` rises in the same cycle the SET state is entered. It falls one cycle after `commit`, or in the same cycle as `abort`.
- Timeout: `abort` asserts `SET_TIMEOUT` cycles after the last event registered in SET.
- `commit` and `abort` are mutually exclusive. A set event in the cycle the timer expires wins, giving COMMIT.

## Structure
- **Package `watch_pkg`:**
  - Mode constants WATCH, STOPWATCH, ALARM, DAY (3 bits).
  - State encoding BROWSE, SET, COMMIT.
  - Field count 4.
- **Sub-module `button_debouncer`:** synchronizer, debounce counter, and rising-edge pulse. Parameter `DEBOUNCE_CYCLES`. Instantiated four times.
- **Top:** event priority, FSM, `field` counter, idle timer.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SET_TIMEOUT`=32.
- **Mode cycling:** five clean `btn_mode` presses from reset → `mode` 1,2,3,0,1; each change 7 cycles after the raw rise.
- **Bounce rejection:** `btn_mode` toggling every 2 cycles for 20 cycles, then stable 0 → no mode change.
- **ALARM edit:** with `mode`=2, press set; then next ×5; then up ×2; then set.
  - `setValue`=1; `field` 1,2,3,0,1; 5 `nextd` pulses; 2 `upTime` pulses.
  - One `commit` pulse, then `setValue`=0 and `field`=0.
- **STOPWATCH and DAY edits:**
  - `mode`=1, press set → `setValue` stays 0.
  - `mode`=3, press set then next → no `nextd`, `field`=0.
- **Timeout:** enter SET, then no presses → `abort` exactly 32 cycles after the entry event; `setValue`=0; no `commit`.
- **Simultaneous and reset cases:**
  - Set and mode accepted in the same cycle → SET entered and `mode` unchanged.
  - `reset` asserted during SET → all outputs 0 on the next cycle, no `commit` or `abort`.
